x_delay_line_ctrl: RTL and testbench
====================================

// Module: x_delay_line_ctrl
// PURPOSE
// Measurement sequencer for the tapped delay line. On request it enables the line and waits a settle period.
// It then captures 2^n consecutive 32-tap snapshots and decodes each into an edge position.
// Result min/max/sum and a bubble count are presented on a valid/ready result port.
// Sits between the delay line (o_data) and the host-facing register/IO logic.
// PARAMETERS
// W        32  number of delay-line taps (data width); position width PW = $clog2(W+1) = 6
// SETTLE    4  cycles o_dl_en is held high before the first sample is taken (>=1)
// PORTS
// i_clk         in   1      clock
// i_rst_n       in   1      asynchronous active-low reset
// i_req         in   1      start measurement; sampled only in IDLE
// i_abort       in   1      synchronous abort; returns to IDLE, no result produced
// i_cfg_log2n   in   3      sample count N = 2^i_cfg_log2n (1..128); latched on accept
// i_dl_data     in   W      delay-line tap snapshot
// o_dl_en       out  1      delay-line enable; high in SETTLE and SAMPLE only
// o_busy        out  1      high in any state except IDLE
// o_valid       out  1      result valid; high only in DONE
// i_ready       in   1      result consumer ready
// o_min         out  6      minimum decoded position over the run
// o_max         out  6      maximum decoded position over the run
// o_sum         out  13     sum of decoded positions (PW+7 bits; cannot overflow)
// o_bubbles     out  8      count of non-monotonic samples, saturating at 255
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; input register d_q=0; counters 0.
// - d_q <= i_dl_data every cycle (one sync stage). All decoding uses d_q.
// - Decode of d_q:
//   - pos = index of the lowest bit i>0 with d_q[i] != d_q[0]; pos = W if none.
//   - Range is 1..W; d_q[0] is the reference polarity, so both line polarities decode identically.
//   - bubble = more than one transition between adjacent bits of d_q.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE: i_req=1 (and i_abort=0) -> SETTLE.
//     - On accept: latch N; cnt=0; o_min=6'h3F; o_max=0; o_sum=0; o_bubbles=0.
//   - SETTLE: cnt increments each cycle. -> SAMPLE when cnt==SETTLE-1; cnt cleared.
//   - SAMPLE: each cycle fold pos into min/max/sum; bubble -> o_bubbles+1 (saturate).
//     - -> DONE after the N-th fold (cnt==N-1).
//   - DONE: o_valid=1; o_min/o_max/o_sum/o_bubbles held stable. o_valid&&i_ready -> IDLE.
// - Latency: i_req accepted at cycle t.
//   - SETTLE occupies t+1..t+SETTLE; SAMPLE occupies t+SETTLE+1..t+SETTLE+N.
//   - o_valid rises at t+SETTLE+N+1.
// - i_req outside IDLE is ignored (not queued).
// - i_req in the same cycle as the DONE handshake is ignored; it is accepted the next cycle in IDLE.
// - i_abort in SETTLE/SAMPLE/DONE -> IDLE next cycle.
//   - o_valid drops; result registers keep their last values; o_dl_en=0.
//   - i_abort has priority over i_req and over the handshake.
// - Async reset mid-run returns to IDLE immediately with all outputs 0.
// - i_cfg_log2n changes after accept have no effect on the current run.
// - o_dl_en, o_busy and o_valid are decoded from registered state (glitch-free).
// TESTING
// - Clean thermometer: i_dl_data=32'h0000_FFFF const, log2n=2
//   -> o_valid at t+4+4+1; min=max=16, sum=64, bubbles=0.
// - Alternating polarity: i_dl_data alternates 32'h0000_00FF / 32'hFFFF_FF00, log2n=3
//   -> min=max=8, sum=64.
// - Bubble: 32'h0000_F0FF for one of 4 samples, remainder 32'h0000_00FF
//   -> bubbles=1; sum includes pos=8 for the bubble sample.
// - Boundaries: all-ones sample -> pos=32; log2n=7 with all-ones -> sum=4096.
//   Positions ramp 1..32 -> min=1, max=32.
// - Backpressure/handshake: hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_busy=1.
//   Raise i_ready together with i_req -> IDLE, then the req re-asserted next cycle starts a run.
// - Abort/reset: i_abort in SAMPLE -> IDLE next cycle, o_valid never rises, o_dl_en=0.
//   i_rst_n low mid-SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/x_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : x_delay_line_ctrl
//  Purpose  : Measurement sequencer for a tapped delay line. On request it
//             enables the line, waits a settle period, then captures 2^n
//             snapshots. Each snapshot is decoded into an edge position, and
//             min/max/sum/bubble-count are reported on a valid/ready port.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_req, i_abort, i_cfg_log2n[2:0]      - run control
//             i_dl_data[W-1:0], o_dl_en             - delay-line side
//             o_busy, o_valid, i_ready              - status / result handshake
//             o_min, o_max [PW-1:0], o_sum [PW+6:0],
//             o_bubbles [7:0]                       - result
//  Revision : 1.0  initial release
// ============================================================================
module x_delay_line_ctrl #(
  parameter int W      = 32,
  parameter int SETTLE = 4,
  localparam int PW    = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_abort,
  input  logic [2:0]    i_cfg_log2n,
  input  logic [W-1:0]  i_dl_data,
  output logic          o_dl_en,
  output logic          o_busy,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_min,
  output logic [PW-1:0] o_max,
  output logic [PW+6:0] o_sum,
  output logic [7:0]    o_bubbles
);

  // Counter must cover both the settle period and the largest run (128).
  localparam int CW = ($clog2(SETTLE) > 7) ? $clog2(SETTLE) : 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e          state_q;
  logic [W-1:0]    d_q;
  logic [CW-1:0]   cnt_q;
  logic [6:0]      nm1_q;      // N-1 for the current run
  logic            dl_en_q;
  logic            busy_q;
  logic            valid_q;
  logic [PW-1:0]   min_q;
  logic [PW-1:0]   max_q;
  logic [PW+6:0]   sum_q;
  logic [7:0]      bub_q;

  logic [PW-1:0]   pos_d;
  logic [W-2:0]    trans_d;
  logic            bubble_d;

  // Edge position: lowest tap differing from tap 0. Scanning downwards lets
  // the lowest match win; no match means the edge is beyond the line.
  always_comb begin
    pos_d = PW'(W);
    for (int i = W - 1; i >= 1; i--) begin
      if (d_q[i] != d_q[0]) pos_d = PW'(i);
    end
  end

  // A clean thermometer has at most one adjacent-bit transition; clearing
  // the lowest set bit leaves something only if there were two or more.
  assign trans_d  = d_q[W-1:1] ^ d_q[W-2:0];
  assign bubble_d = (trans_d & (trans_d - {{(W-2){1'b0}}, 1'b1})) != '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
      nm1_q   <= '0;
      dl_en_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      bub_q   <= '0;
    end else begin
      d_q <= i_dl_data;
      if (i_abort && (state_q != S_IDLE)) begin
        // Abort wins over everything; result registers keep their values.
        state_q <= S_IDLE;
        dl_en_q <= 1'b0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_req && !i_abort) begin
              state_q <= S_SETTLE;
              nm1_q   <= 7'((8'd1 << i_cfg_log2n) - 8'd1);
              cnt_q   <= '0;
              min_q   <= '1;
              max_q   <= '0;
              sum_q   <= '0;
              bub_q   <= '0;
              dl_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
              state_q <= S_SAMPLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SAMPLE: begin
            if (pos_d < min_q) min_q <= pos_d;
            if (pos_d > max_q) max_q <= pos_d;
            sum_q <= sum_q + {7'd0, pos_d};
            if (bubble_d && (bub_q != 8'hFF)) bub_q <= bub_q + 1'b1;
            if (cnt_q == CW'(nm1_q)) begin
              state_q <= S_DONE;
              dl_en_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            if (i_ready) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            dl_en_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dl_en   = dl_en_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_min     = min_q;
  assign o_max     = max_q;
  assign o_sum     = sum_q;
  assign o_bubbles = bub_q;

endmodule
`default_nettype wire

// File: tb/tb_x_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_delay_line_ctrl
//  Purpose  : Self-checking bench for x_delay_line_ctrl. Sample sets are
//             reduced to expected min/max/sum/bubbles with plain arithmetic
//             and compared at the cycle the result becomes valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_x_delay_line_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, abort_s, ready;
  logic [2:0]  cfg;
  logic [31:0] dl;
  logic        dl_en, busy, valid;
  logic [5:0]  mn, mx;
  logic [12:0] sum;
  logic [7:0]  bub;

  logic [31:0] smp [0:127];
  int          n_checks = 0;
  int          n_errors = 0;

  x_delay_line_ctrl #(.W(32), .SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_abort     (abort_s),
    .i_cfg_log2n (cfg),
    .i_dl_data   (dl),
    .o_dl_en     (dl_en),
    .o_busy      (busy),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_min       (mn),
    .o_max       (mx),
    .o_sum       (sum),
    .o_bubbles   (bub)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input logic [31:0] v);
    int p;
    p = 32;
    for (int i = 31; i >= 1; i--) if (v[i] != v[0]) p = i;
    return p;
  endfunction

  function automatic bit bubble_of(input logic [31:0] v);
    int t;
    t = 0;
    for (int i = 1; i < 32; i++) if (v[i] != v[i-1]) t++;
    return t > 1;
  endfunction

  function automatic logic [31:0] gen_word();
    int          p;
    logic [31:0] w;
    p = $urandom_range(1, 32);
    w = (p == 32) ? 32'hFFFF_FFFF : ((32'd1 << p) - 32'd1);
    if ($urandom_range(0, 1) == 1) w = ~w;
    if ($urandom_range(0, 3) == 0) w = w ^ (32'd1 << $urandom_range(1, 31));
    return w;
  endfunction

  // One complete measurement of 2^lg samples taken from smp[].
  task automatic run_meas(input int lg, input int hold, input bit req_at_hs);
    int n, e_min, e_max, e_sum, e_bub, p;
    n = 1 << lg;
    e_min = 1000; e_max = 0; e_sum = 0; e_bub = 0;
    for (int k = 0; k < n; k++) begin
      p = pos_of(smp[k]);
      if (p < e_min) e_min = p;
      if (p > e_max) e_max = p;
      e_sum += p;
      if (bubble_of(smp[k]) && e_bub < 255) e_bub++;
    end
    // cycle t: request accepted at the end of this cycle
    @(posedge clk); #1 req = 1'b1; cfg = 3'(lg); dl = smp[0]; ready = 1'b0;
    @(posedge clk); #1 req = 1'($urandom_range(0, 1)); cfg = 3'($urandom);
    @(negedge clk);
    chk("settle_en", dl_en, 1); chk("settle_busy", busy, 1); chk("settle_valid", valid, 0);
    repeat (SETTLE - 1) begin @(posedge clk); #1 req = 1'($urandom_range(0, 1)); end
    // snapshot k must be on the line during cycle t+SETTLE+k
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1 dl = smp[k]; req = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 req = 1'b0; dl = $urandom;
    @(negedge clk);
    chk("last_sample_valid", valid, 0); chk("last_sample_en", dl_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_valid", valid, 1); chk("done_en", dl_en, 0); chk("done_busy", busy, 1);
    chk("min", mn, e_min); chk("max", mx, e_max); chk("sum", sum, e_sum); chk("bubbles", bub, e_bub);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1 req = 1'($urandom_range(0, 1)); dl = $urandom; end
      @(negedge clk);
      chk("hold_valid", valid, 1); chk("hold_busy", busy, 1);
      chk("hold_min", mn, e_min); chk("hold_max", mx, e_max);
      chk("hold_sum", sum, e_sum); chk("hold_bub", bub, e_bub);
    end
    @(posedge clk); #1 ready = 1'b1; req = req_at_hs; cfg = 3'd7;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    chk("hs_busy", busy, 0); chk("hs_valid", valid, 0);
    if (req_at_hs) begin
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("rereq_busy", busy, 1); chk("rereq_en", dl_en, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    rst_n = 1'b0; req = 1'b0; abort_s = 1'b0; ready = 1'b0; cfg = '0; dl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", dl_en, 0); chk("rst_busy", busy, 0); chk("rst_valid", valid, 0);
    chk("rst_min", mn, 0); chk("rst_max", mx, 0); chk("rst_sum", sum, 0); chk("rst_bub", bub, 0);
    #2 rst_n = 1'b1;

    // clean thermometer, with 10 cycles of backpressure
    for (int k = 0; k < 4; k++) smp[k] = 32'h0000_FFFF;
    run_meas(2, 10, 1'b0);
    // alternating polarity
    for (int k = 0; k < 8; k++) smp[k] = (k % 2 == 0) ? 32'h0000_00FF : 32'hFFFF_FF00;
    run_meas(3, 0, 1'b0);
    // one bubbled snapshot
    for (int k = 0; k < 4; k++) smp[k] = 32'h0000_00FF;
    smp[1] = 32'h0000_F0FF;
    run_meas(2, 0, 1'b0);
    // all ones, longest run
    for (int k = 0; k < 128; k++) smp[k] = 32'hFFFF_FFFF;
    run_meas(7, 0, 1'b0);
    // position ramp 1..32, then handshake together with a new request
    for (int k = 0; k < 32; k++) smp[k] = (k == 31) ? 32'hFFFF_FFFF : ((32'd1 << (k + 1)) - 32'd1);
    run_meas(5, 2, 1'b1);

    // new run (N=128) started by the request above; abort it in SAMPLE
    repeat (5) @(posedge clk);
    #1 abort_s = 1'b1;
    @(posedge clk); #1 abort_s = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_en", dl_en, 0); chk("abort_valid", valid, 0);
    vcnt = 0;
    repeat (12) begin @(negedge clk); if (valid) vcnt++; end
    chk("abort_no_valid", vcnt, 0);

    // asynchronous reset in SETTLE
    @(posedge clk); #1 req = 1'b1; cfg = 3'd2;
    @(posedge clk); #1 req = 1'b0;
    chk("accept_min", mn, 6'h3F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", dl_en, 0); chk("arst_busy", busy, 0); chk("arst_valid", valid, 0);
    chk("arst_min", mn, 0); chk("arst_sum", sum, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      int lg;
      lg = $urandom_range(0, 5);
      for (int k = 0; k < (1 << lg); k++) smp[k] = gen_word();
      run_meas(lg, $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
